// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Operand-issue stage in front of the 32-bit ALU. Decoded R/I-type ops come in over a
//   valid/ready handshake. The stage selects and extends operand B, maps funct onto the
//   ALU controls (opcode, Cin, B inversion) and registers the result. A 2-entry skid
//   buffer means a downstream stall never drops an op.
//
//   Ports
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     flush             synchronous discard of every buffered op
//     in_*              upstream op: valid/ready, funct, rs, rt, imm, use_imm, sign_ext
//     out_*             ALU operands: valid/ready, a, b (pre-inverted), cin, opcode,
//                       slt flag, illegal flag
//     issue_cnt         count of output handshakes, wraps
//
//   WIDTH must be larger than 16 because the immediate is extended into bits [WIDTH-1:16].
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    input  logic [15:0]      in_imm,
    input  logic             in_use_imm,
    input  logic             in_sign_ext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_cin,
    output logic [1:0]       out_opcode,
    output logic             out_slt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [1:0]       opcode;
        logic             slt;
        logic             illegal;
    } op_t;

    localparam logic [1:0] OPC_AND = 2'd0;
    localparam logic [1:0] OPC_OR  = 2'd1;
    localparam logic [1:0] OPC_ADD = 2'd2;
    localparam logic [1:0] OPC_XOR = 2'd3;

    op_t              dec_op;
    op_t              out_q;
    op_t              skid_q;
    logic             out_vld;
    logic             skid_vld;
    logic             inv_b;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] b_sel;
    logic             accept;
    logic             issue;

    // ---------------- decode (input side, before registering) ----------------
    assign imm_ext = {{(WIDTH-16){in_sign_ext & in_imm[15]}}, in_imm};
    assign b_sel   = in_use_imm ? imm_ext : in_rt;

    always_comb begin
        dec_op         = '0;
        inv_b          = 1'b0;
        dec_op.a       = in_rs;
        dec_op.opcode  = OPC_AND;
        case (in_funct)
            6'h20, 6'h21: dec_op.opcode = OPC_ADD;
            6'h22, 6'h23: begin
                dec_op.opcode = OPC_ADD;
                dec_op.cin    = 1'b1;
                inv_b         = 1'b1;
            end
            6'h24: dec_op.opcode = OPC_AND;
            6'h25: dec_op.opcode = OPC_OR;
            6'h26: dec_op.opcode = OPC_XOR;
            // slt is a subtract; downstream reads the sign of the sum
            6'h2A: begin
                dec_op.opcode = OPC_ADD;
                dec_op.cin    = 1'b1;
                dec_op.slt    = 1'b1;
                inv_b         = 1'b1;
            end
            default: dec_op.illegal = 1'b1;
        endcase
        // inversion follows source selection so subtract-immediate works too
        dec_op.b = inv_b ? ~b_sel : b_sel;
    end

    // ---------------- handshake ----------------
    // in_ready comes straight from the skid flop: no combinational path from out_ready
    assign in_ready = ~skid_vld;
    assign accept   = in_valid & ~skid_vld & ~flush;
    assign issue    = out_vld & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            // data regs keep their contents; only the valids matter
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!out_vld || issue) begin
            // output slot free this cycle: oldest op (skid first) moves in
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                out_q   <= dec_op;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (accept) begin
            // output held by a stall: park the new op in the skid slot
            skid_q   <= dec_op;
            skid_vld <= 1'b1;
        end
    end

    // issue_cnt counts handshakes even on a flush cycle and ignores flush otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     issue_cnt <= '0;
        else if (issue) issue_cnt <= issue_cnt + 1'b1;
    end

    assign out_valid   = out_vld;
    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_cin     = out_q.cin;
    assign out_opcode  = out_q.opcode;
    assign out_slt     = out_q.slt;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [1:0]  op;
        logic        slt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic        ui;
        logic        sx;
        exp_t        e;
    } vec_t;

    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_funct = '0;
    logic [31:0] in_rs = '0;
    logic [31:0] in_rt = '0;
    logic [15:0] in_imm = '0;
    logic        in_use_imm = 1'b0;
    logic        in_sign_ext = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_cin;
    logic [1:0]  out_opcode;
    logic        out_slt;
    logic        out_illegal;
    logic [15:0] issue_cnt;

    exp_t drv_exp;
    exp_t sb[$];
    vec_t vecs[NV];
    int   errors = 0;
    int   checks = 0;

    alu_issue_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_cin(out_cin), .out_opcode(out_opcode), .out_slt(out_slt),
        .out_illegal(out_illegal), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference decode written from the opcode table
    function automatic exp_t model(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm, input logic ui, input logic sx);
        exp_t m;
        logic [31:0] b;
        if (!ui)     b = rt;
        else if (sx) b = {{16{imm[15]}}, imm};
        else         b = {16'h0000, imm};
        m = '{a: rs, b: b, cin: 1'b0, op: 2'd0, slt: 1'b0, ill: 1'b0};
        case (f)
            6'h20, 6'h21: m.op = 2'd2;
            6'h22, 6'h23: begin m.op = 2'd2; m.cin = 1'b1; m.b = ~b; end
            6'h24: m.op = 2'd0;
            6'h25: m.op = 2'd1;
            6'h26: m.op = 2'd3;
            6'h2A: begin m.op = 2'd2; m.cin = 1'b1; m.b = ~b; m.slt = 1'b1; end
            default: m.ill = 1'b1;
        endcase
        return m;
    endfunction

    function automatic vec_t mk(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] imm, input logic ui, input logic sx,
                                input logic [31:0] ea, input logic [31:0] eb, input logic ec,
                                input logic [1:0] eo, input logic es, input logic ei);
        vec_t v;
        v.funct = f; v.rs = rs; v.rt = rt; v.imm = imm; v.ui = ui; v.sx = sx;
        v.e = '{a: ea, b: eb, cin: ec, op: eo, slt: es, ill: ei};
        return v;
    endfunction

    // Scoreboard: push on accept, pop on issue, drop everything on flush/reset
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got op a=%0h with nothing expected", out_a);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({out_a, out_b, out_cin, out_opcode, out_slt, out_illegal} !== e) begin
                        errors++;
                        $display("FAIL issue_op: got a=%h b=%h cin=%b op=%0d slt=%b ill=%b want a=%h b=%h cin=%b op=%0d slt=%b ill=%b",
                                 out_a, out_b, out_cin, out_opcode, out_slt, out_illegal,
                                 e.a, e.b, e.cin, e.op, e.slt, e.ill);
                    end
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(drv_exp);
        end
    end

    task automatic set_op(input vec_t v);
        in_funct = v.funct; in_rs = v.rs; in_rt = v.rt; in_imm = v.imm;
        in_use_imm = v.ui; in_sign_ext = v.sx; drv_exp = v.e;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input vec_t v);
        int n;
        set_op(v);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 80'd0, 80'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_left", 80'(sb.size()), 80'd0);
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.funct = 6'h00; v.rs = i; v.rt = ~i; v.imm = i[15:0]; v.ui = i[0]; v.sx = i[1];
            v.e = model(v.funct, v.rs, v.rt, v.imm, v.ui, v.sx);
            set_op(v);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(6'h20, 32'h5,  32'h7,        16'h0,    0, 0, 32'h5,  32'h7,        0, 2'd2, 0, 0);
        vecs[1]  = mk(6'h21, 32'h1,  32'hFFFFFFFF, 16'h0,    0, 0, 32'h1,  32'hFFFFFFFF, 0, 2'd2, 0, 0);
        vecs[2]  = mk(6'h22, 32'h9,  32'h3,        16'h0,    0, 0, 32'h9,  32'hFFFFFFFC, 1, 2'd2, 0, 0);
        vecs[3]  = mk(6'h23, 32'h0,  32'h0,        16'h0,    0, 0, 32'h0,  32'hFFFFFFFF, 1, 2'd2, 0, 0);
        vecs[4]  = mk(6'h2A, 32'h9,  32'h3,        16'h0,    0, 0, 32'h9,  32'hFFFFFFFC, 1, 2'd2, 1, 0);
        vecs[5]  = mk(6'h24, 32'hF0, 32'h3C,       16'h0,    0, 0, 32'hF0, 32'h3C,       0, 2'd0, 0, 0);
        vecs[6]  = mk(6'h25, 32'hF0, 32'h3C,       16'h0,    0, 0, 32'hF0, 32'h3C,       0, 2'd1, 0, 0);
        vecs[7]  = mk(6'h26, 32'hF0, 32'h3C,       16'h0,    0, 0, 32'hF0, 32'h3C,       0, 2'd3, 0, 0);
        vecs[8]  = mk(6'h20, 32'h1,  32'h123,      16'h8001, 1, 1, 32'h1,  32'hFFFF8001, 0, 2'd2, 0, 0);
        vecs[9]  = mk(6'h20, 32'h1,  32'h123,      16'h8001, 1, 0, 32'h1,  32'h00008001, 0, 2'd2, 0, 0);
        vecs[10] = mk(6'h22, 32'h10, 32'h0,        16'h0001, 1, 1, 32'h10, 32'hFFFFFFFE, 1, 2'd2, 0, 0);
        vecs[11] = mk(6'h00, 32'h4,  32'h6,        16'h0,    0, 0, 32'h4,  32'h6,        0, 2'd0, 0, 1);
        vecs[12] = mk(6'h3F, 32'h4,  32'h6,        16'h7FFF, 1, 1, 32'h4,  32'h00007FFF, 0, 2'd0, 0, 1);
        vecs[13] = mk(6'h22, 32'h2,  32'h0,        16'h8000, 1, 1, 32'h2,  32'h00007FFF, 1, 2'd2, 0, 0);
        vecs[14] = mk(6'h2A, 32'h3,  32'h0,        16'hFFFF, 1, 0, 32'h3,  32'hFFFF0000, 1, 2'd2, 1, 0);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 80'(out_valid), 80'd0);
        chk("rst_in_ready",  80'(in_ready),  80'd1);
        chk("rst_out_a",     80'(out_a),     80'd0);
        chk("rst_out_b",     80'(out_b),     80'd0);
        chk("rst_ctl",       80'({out_cin, out_opcode, out_slt, out_illegal}), 80'd0);
        chk("rst_issue_cnt", 80'(issue_cnt), 80'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // decode table, one op at a time; out_valid one cycle after accept
        for (int i = 0; i < NV; i++) begin
            send(vecs[i]);
            @(negedge clk);
            chk($sformatf("latency_%0d", i), 80'(out_valid), 80'd1);
            drain();
        end
        chk("cnt_after_table", 80'(issue_cnt), 80'd15);

        // stall: two ops held, third waits, then in-order release
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[2]);
        @(negedge clk);
        chk("stall_in_ready",  80'(in_ready),  80'd0);
        chk("stall_out_valid", 80'(out_valid), 80'd1);
        chk("stall_out_a",     80'(out_a),     80'h5);
        set_op(vecs[5]);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("stall_stable_a", 80'(out_a), 80'h5);
        chk("stall_stable_b", 80'(out_b), 80'h7);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(vecs[5]);
        drain();
        chk("cnt_after_stall", 80'(issue_cnt), 80'd18);

        // flush with skid full (offered op cannot enter)
        out_ready = 1'b0;
        send(vecs[7]);
        send(vecs[3]);
        set_op(vecs[6]);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 80'(out_valid), 80'd0);
        chk("flush_in_ready",  80'(in_ready),  80'd1);

        // flush with same-cycle accept and issue: op dropped, issue still counted
        @(posedge clk); #1;
        send(vecs[1]);
        set_op(vecs[6]);
        in_valid = 1'b1;
        out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush2_out_valid", 80'(out_valid), 80'd0);
        chk("flush2_in_ready",  80'(in_ready),  80'd1);
        chk("flush2_cnt",       80'(issue_cnt), 80'd19);
        repeat (3) @(negedge clk);
        chk("flush2_dropped", 80'(out_valid), 80'd0);
        @(posedge clk); #1;

        // counter wrap at full throughput
        stream(65535 - 19);
        drain();
        chk("cnt_max", 80'(issue_cnt), 80'hFFFF);
        stream(1);
        drain();
        chk("cnt_wrap", 80'(issue_cnt), 80'd0);

        // reset mid-operation clears everything at once
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[2]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 80'(out_valid), 80'd0);
        chk("mrst_in_ready",  80'(in_ready),  80'd1);
        chk("mrst_out_b",     80'(out_b),     80'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(vecs[4]);
        drain();
        chk("mrst_cnt", 80'(issue_cnt), 80'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
